// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pulls bytes out of the UART receive FIFO, parses a framed
// program image (sync, 16-bit word count, little-endian words, 8-bit checksum)
// and writes the assembled 32-bit words into instruction memory.
module uart_boot_loader #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned TIMEOUT  = 2000000,
    parameter logic [7:0]  SYNC     = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [7:0]        RX_STATUS,
    input  logic [7:0]        RX_DATA,
    output logic [7:0]        RX_CONTROL,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);
    localparam int unsigned LAT_W  = $clog2(READ_LAT + 1) + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_N  = 17'(1) << ADDR_W;

    localparam logic [1:0] F_POLL = 2'd0;
    localparam logic [1:0] F_WAIT = 2'd1;
    localparam logic [1:0] F_HOLD = 2'd2;

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    // byte fetch state
    logic [1:0]        fst_q, fst_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              pop_q, pop_d;
    logic              bvalid_q, bvalid_d;
    logic [7:0]        byte_q, byte_d;

    // frame state
    logic [2:0]        st_q, st_d;
    logic [7:0]        lenlo_q, lenlo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [16:0]       nlen;

    assign nlen       = {1'b0, byte_q, lenlo_q};
    assign RX_CONTROL = {7'b0, pop_q};
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_WDATA  = wdata_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

    // Fetch FSM: one pop per byte, wait out the read latency, then one idle
    // cycle so the registered FIFO status catches up with the pop.
    always_comb begin
        fst_d    = fst_q;
        lat_d    = lat_q;
        pop_d    = 1'b0;
        bvalid_d = 1'b0;
        byte_d   = byte_q;
        case (fst_q)
            F_POLL: begin
                if (EN && (RX_STATUS != 8'h00)) begin
                    pop_d = 1'b1;
                    lat_d = '0;
                    fst_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (lat_q == LAT_W'(READ_LAT)) begin
                    byte_d   = RX_DATA;
                    bvalid_d = 1'b1;
                    fst_d    = F_HOLD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            F_HOLD:  fst_d = F_POLL;
            default: fst_d = F_POLL;
        endcase
    end

    // Frame FSM plus inter-byte timeout; acts only on a fetched byte or expiry.
    always_comb begin
        st_d    = st_q;
        lenlo_d = lenlo_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        tcnt_d  = tcnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // address moves on once the write strobe has been presented
        if (we_q) addr_d = addr_q + 1'b1;
        if (busy_q) tcnt_d = tcnt_q + 1'b1;

        if (bvalid_q) begin
            // counter holds the number of cycles since the last byte valid
            tcnt_d = TCNT_W'(1);
            case (st_q)
                S_SYNC: begin
                    if (byte_q == SYNC) begin
                        st_d   = S_LEN0;
                        busy_d = 1'b1;
                        done_d = 1'b0;
                        err_d  = 1'b0;
                        csum_d = '0;
                        addr_d = '0;
                        wcnt_d = '0;
                        bidx_d = '0;
                    end
                end
                S_LEN0: begin
                    lenlo_d = byte_q;
                    st_d    = S_LEN1;
                end
                S_LEN1: begin
                    if (nlen > MAX_N) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                        st_d   = S_SYNC;
                    end else if (nlen == 17'd0) begin
                        st_d = S_CHK;
                    end else begin
                        n_d  = nlen[ADDR_W:0];
                        st_d = S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d = csum_q + byte_q;
                    word_d = {byte_q, word_q[23:8]};
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_q, word_q};
                        wcnt_d  = wcnt_q + 1'b1;
                        if ((wcnt_q + 1'b1) == n_q) st_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (byte_q == csum_q) done_d = 1'b1;
                    else                  err_d  = 1'b1;
                    busy_d = 1'b0;
                    st_d   = S_SYNC;
                end
                default: st_d = S_SYNC;
            endcase
        end else if (busy_q && (tcnt_q == TCNT_W'(TIMEOUT - 1))) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            st_d   = S_SYNC;
        end
    end

    // State registers; active-low synchronous reset clears everything.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            fst_q    <= F_POLL;
            lat_q    <= '0;
            pop_q    <= 1'b0;
            bvalid_q <= 1'b0;
            byte_q   <= '0;
            st_q     <= S_SYNC;
            lenlo_q  <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            csum_q   <= '0;
            tcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            fst_q    <= fst_d;
            lat_q    <= lat_d;
            pop_q    <= pop_d;
            bvalid_q <= bvalid_d;
            byte_q   <= byte_d;
            st_q     <= st_d;
            lenlo_q  <= lenlo_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            csum_q   <= csum_d;
            tcnt_q   <= tcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a FIFO model plays the receive block, a frame
// model predicts memory writes and final flags, and a per-cycle monitor checks
// every write strobe and pop against those predictions.
module tb_uart_boot_loader;
    localparam int ADDR_W   = 10;
    localparam int READ_LAT = 1;
    localparam int TIMEOUT  = 100;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              EN  = 1'b0;
    logic [7:0]        RX_STATUS = 8'h00;
    logic [7:0]        RX_DATA   = 8'h00;
    logic [7:0]        RX_CONTROL;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    always #5 CLK = ~CLK;

    uart_boot_loader #(
        .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .RX_STATUS(RX_STATUS), .RX_DATA(RX_DATA), .RX_CONTROL(RX_CONTROL),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0]        fifo[$];
    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    bit                exp_done, exp_err;
    int                exp_lat;

    int                cyc = 0;
    int                last_pop_cyc = 0;
    int                pop_cnt = 0;
    logic              prev_pop = 1'b0;
    logic [7:0]        prev_status = 8'h00;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor and receive-FIFO model, both on the falling edge.
    always @(negedge CLK) begin
        if (MEM_WE) begin
            if (exp_addr.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_we: write of %h at %h, expected no write", MEM_WDATA, MEM_ADDR);
            end else begin
                check("we_addr", 32'(MEM_ADDR), 32'(exp_addr.pop_front()));
                check("we_data", MEM_WDATA, exp_data.pop_front());
            end
            last_addr  = MEM_ADDR;
            last_wdata = MEM_WDATA;
        end
        if (RX_CONTROL[0]) begin
            check("pop_back_to_back", 32'(prev_pop), 32'd0);
            check("pop_with_status", 32'(prev_status != 8'h00), 32'd1);
            check("rx_ctrl_upper", 32'(RX_CONTROL[7:1]), 32'd0);
            pop_cnt++;
            last_pop_cyc = cyc;
            if (fifo.size() != 0) RX_DATA = fifo.pop_front();
        end
        RX_STATUS   = (fifo.size() != 0) ? 8'h01 : 8'h00;
        prev_pop    = RX_CONTROL[0];
        prev_status = RX_STATUS;
    end

    // Frame model: what the loader must do with the byte stream in stim.
    task automatic model();
        int i;
        int n;
        int s;
        i = 0;
        s = 0;
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_lat  = READ_LAT + 2;
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        i++;
        n = int'(stim[i]) + 256 * int'(stim[i+1]);
        i += 2;
        if (n > (1 << ADDR_W)) return;
        for (int k = 0; k < n; k++) begin
            if (i + 4 > stim.size()) begin
                exp_lat = READ_LAT + 1 + TIMEOUT;
                return;
            end
            exp_addr.push_back(ADDR_W'(k));
            exp_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
            s += int'(stim[i]) + int'(stim[i+1]) + int'(stim[i+2]) + int'(stim[i+3]);
            i += 4;
        end
        if (i >= stim.size()) begin
            exp_lat = READ_LAT + 1 + TIMEOUT;
            return;
        end
        exp_done = (stim[i] == 8'(s));
        exp_err  = !exp_done;
    endtask

    task automatic start_frame();
        model();
        foreach (stim[k]) fifo.push_back(stim[k]);
    endtask

    task automatic finish_frame(input string name);
        int guard;
        guard = 0;
        while (fifo.size() != 0 && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            chk_cnt++;
            $display("FAIL %s_drain: %0d bytes left unread, expected 0", name, fifo.size());
            return;
        end
        guard = 0;
        while (cyc < last_pop_cyc + exp_lat - 1 && guard < 500) begin
            tick();
            guard++;
        end
        check({name, "_pre"}, 32'({BUSY, DONE, ERR}), 32'(3'b100));
        tick();
        check({name, "_flags"}, 32'({BUSY, DONE, ERR}), 32'({1'b0, exp_done, exp_err}));
        check({name, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        int p0;
        int guard;

        // reset values
        RST = 1'b0;
        EN  = 1'b1;
        repeat (3) tick();
        check("rst_rx_control", 32'(RX_CONTROL), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_wdata", MEM_WDATA, 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        RST = 1'b1;
        tick();

        // single word
        stim = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        start_frame();
        finish_frame("one_word");
        check("one_word_data", last_wdata, 32'h12345678);
        check("one_word_addr", 32'(last_addr), 32'd0);
        check("one_word_addr_after", 32'(MEM_ADDR), 32'd1);

        // garbage then two words, good checksum
        p0 = pop_cnt;
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        start_frame();
        finish_frame("two_words");
        check("two_words_pops", 32'(pop_cnt - p0), 32'd14);
        check("two_words_last_data", last_wdata, 32'h08070605);
        check("two_words_last_addr", 32'(last_addr), 32'd1);
        check("two_words_addr_after", 32'(MEM_ADDR), 32'd2);

        // same frame, bad checksum
        stim = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08, 8'h25};
        start_frame();
        finish_frame("bad_csum");
        check("bad_csum_err", 32'({DONE, ERR}), 32'(2'b01));

        // empty image
        stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
        start_frame();
        finish_frame("empty");
        check("empty_done", 32'(DONE), 32'd1);

        // oversize word count, then a good frame
        stim = '{8'hA5, 8'h01, 8'h04};
        start_frame();
        finish_frame("too_long");
        check("too_long_err", 32'(ERR), 32'd1);
        stim = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        start_frame();
        finish_frame("after_too_long");
        check("after_too_long_done", 32'({DONE, ERR}), 32'(2'b10));

        // loader disabled: FIFO left to the CPU
        EN = 1'b0;
        p0 = pop_cnt;
        stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
        start_frame();
        repeat (20) tick();
        check("disabled_no_pop", 32'(pop_cnt - p0), 32'd0);
        EN = 1'b1;
        finish_frame("enabled_again");

        // stalled frame times out
        stim = '{8'hA5, 8'h01, 8'h00, 8'h12};
        start_frame();
        finish_frame("timeout");
        check("timeout_err", 32'(ERR), 32'd1);

        // reset in the middle of the payload
        stim = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        start_frame();
        guard = 0;
        while (fifo.size() != 0 && guard < 2000) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check("mid_busy", 32'(BUSY), 32'd1);
        check("mid_wdata", MEM_WDATA, 32'h04030201);
        RST = 1'b0;
        tick();
        check("mid_rst_rx_control", 32'(RX_CONTROL), 32'd0);
        check("mid_rst_mem_we", 32'(MEM_WE), 32'd0);
        check("mid_rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("mid_rst_mem_wdata", MEM_WDATA, 32'd0);
        check("mid_rst_flags", 32'({BUSY, DONE, ERR}), 32'd0);
        check("mid_rst_writes_left", 32'(exp_addr.size()), 32'd0);
        repeat (3) tick();
        fifo.delete();
        RST = 1'b1;
        repeat (TIMEOUT + 20) tick();
        check("post_rst_idle", 32'({BUSY, DONE, ERR}), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
